note_lane_renderer: RTL and testbench

Scrolling note-lane renderer for the LED-matrix rhythm game. It holds a queue of note slots and scrolls them one pixel column per scroll tick. On request it streams one 7-row RGB bitmap frame, one row at a time, to the matrix driver over a valid/ready handshake. It also reports notes leaving the lane and optionally judges player hits. It sits between the game/sequencer logic and the matrix row driver.

---
 rtl/note_pkg.sv | 39 +++
 rtl/note_row_compose.sv | 31 +++
 rtl/note_lane_renderer.sv | 172 +++++++++++++++++
 tb/tb_note_lane_renderer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// note_pkg: shared types and glyph ROM for the note-lane renderer.
//   note_kind_t  : 2-bit note kind (empty/red/blue/gold)
//   rend_state_t : renderer FSM states
//   GLYPH        : [kind][row] 7x7 RGB glyph rows, pixel x at bits [x*3 +: 3]
//                  pixel colour is {R,G,B}
package note_pkg;

   typedef enum logic [1:0] {
      KIND_EMPTY = 2'd0,
      KIND_RED   = 2'd1,
      KIND_BLUE  = 2'd2,
      KIND_GOLD  = 2'd3
   } note_kind_t;

   typedef enum logic {
      ST_IDLE,
      ST_EMIT
   } rend_state_t;

   localparam int NOTE_W    = 7;
   localparam int NOTE_ROWS = 7;
   localparam int GLYPH_W   = NOTE_W * 3;

   // Ring glyphs: border pixels lit, interior uses a fill colour.
   localparam logic [GLYPH_W-1:0] RED_FULL  = 21'b100100100100100100100;
   localparam logic [GLYPH_W-1:0] RED_SIDE  = 21'b100000000000000000100;
   localparam logic [GLYPH_W-1:0] BLUE_FULL = 21'b111111111111111111111;
   localparam logic [GLYPH_W-1:0] BLUE_SIDE = 21'b111011011011011011111;
   localparam logic [GLYPH_W-1:0] GOLD_FULL = 21'b110110110110110110110;
   localparam logic [GLYPH_W-1:0] GOLD_SIDE = 21'b110000000000000000110;

   localparam logic [GLYPH_W-1:0] GLYPH [4][NOTE_ROWS] = '{
      '{default: '0},
      '{RED_FULL,  RED_SIDE,  RED_SIDE,  RED_SIDE,  RED_SIDE,  RED_SIDE,  RED_FULL},
      '{BLUE_FULL, BLUE_SIDE, BLUE_SIDE, BLUE_SIDE, BLUE_SIDE, BLUE_SIDE, BLUE_FULL},
      '{GOLD_FULL, GOLD_SIDE, GOLD_SIDE, GOLD_SIDE, GOLD_SIDE, GOLD_SIDE, GOLD_FULL}
   };

endpackage

// File: rtl/note_row_compose.sv
// note_row_compose: combinational row builder.
//   snap     : slot kinds, slot i drawn at lane pixels i*7 .. i*7+6
//   offset   : scroll offset in pixels (0..6)
//   row      : glyph row (0..6)
//   row_data : lane row shifted right by offset pixels, truncated to COLS
module note_row_compose
   import note_pkg::*;
#(
   parameter int SLOTS = 10,
   parameter int COLS  = 64
) (
   input  logic [SLOTS-1:0][1:0] snap,
   input  logic [2:0]            offset,
   input  logic [2:0]            row,
   output logic [COLS*3-1:0]     row_data
);

   localparam int LANE_W = SLOTS * GLYPH_W;

   logic [LANE_W-1:0] lane;
   logic [LANE_W-1:0] shifted;

   for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      assign lane[i*GLYPH_W +: GLYPH_W] = GLYPH[snap[i]][row];
   end

   // offset*3 reaches 18, so widen before multiplying
   assign shifted  = lane >> ({2'b00, offset} * 5'd3);
   assign row_data = shifted[COLS*3-1:0];

endmodule

// File: rtl/note_lane_renderer.sv
// note_lane_renderer: scrolling note lane streamed as 7 RGB rows per frame.
//   note_valid/note_kind/note_ready : push into the single pending-note register
//   scroll_tick / scroll_overrun    : one-pixel scroll request, applied at next frame start
//   frame_req                       : start a frame (IDLE only)
//   row_valid/row_ready/row_idx/row_data : row stream to the matrix driver
//   frame_done                      : pulse after row 6 handshake
//   exit_valid/exit_kind            : a non-empty note left slot 0 (miss)
//   hit/hit_kind/hit_ok/hit_bad     : player hit judging, only with NOTE_HIT_EN defined
module note_lane_renderer
   import note_pkg::*;
#(
   parameter int SLOTS = 10,
   parameter int COLS  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              note_valid,
   input  logic [1:0]        note_kind,
   output logic              note_ready,
   input  logic              scroll_tick,
   output logic              scroll_overrun,
   input  logic              frame_req,
   output logic              row_valid,
   input  logic              row_ready,
   output logic [2:0]        row_idx,
   output logic [COLS*3-1:0] row_data,
   output logic              frame_done,
   output logic              exit_valid,
   output logic [1:0]        exit_kind
`ifdef NOTE_HIT_EN
   ,
   input  logic              hit,
   input  logic [1:0]        hit_kind,
   output logic              hit_ok,
   output logic              hit_bad
`endif
);

   rend_state_t state, state_n;
   logic load_row, row_step, last_row;

   logic [SLOTS-1:0][1:0] slots, snap, slots_sh, slots_nxt;
   logic [2:0]            offset, offset_nxt;
   logic                  pend_full, tick_pend;
   logic [1:0]            pend_kind;
   logic                  push, tick_step, wrap, hit_match;

   logic [SLOTS-1:0][1:0] comp_snap;
   logic [2:0]            comp_off, comp_row;
   logic [COLS*3-1:0]     comp_data;

   assign note_ready = !pend_full && !rst;
   assign push       = note_valid && note_ready;

   // FSM
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n  = state;
      load_row = 1'b0;
      row_step = 1'b0;
      last_row = 1'b0;
      case (state)
         ST_IDLE: if (frame_req) begin
            state_n  = ST_EMIT;
            load_row = 1'b1;
         end
         ST_EMIT: if (row_valid && row_ready) begin
            if (row_idx == 3'd6) begin
               state_n  = ST_IDLE;
               last_row = 1'b1;
            end else begin
               row_step = 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // scroll: only a tick pending before the frame request moves this frame
   assign tick_step  = load_row && tick_pend;
   assign wrap       = tick_step && (offset == 3'd6);
   assign offset_nxt = !tick_step ? offset : (wrap ? 3'd0 : offset + 3'd1);

   always_comb begin
      slots_sh = slots;
      for (int i = 0; i < SLOTS-1; i++) slots_sh[i] = slots[i+1];
      slots_sh[SLOTS-1] = pend_full ? pend_kind : KIND_EMPTY;
   end

   assign slots_nxt = wrap ? slots_sh : slots;

`ifdef NOTE_HIT_EN
   assign hit_match = hit && (slots[0] != KIND_EMPTY) && (hit_kind == slots[0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_ok  <= 1'b0;
         hit_bad <= 1'b0;
      end else begin
         hit_ok  <= hit_match;
         hit_bad <= hit && !hit_match;
      end
   end
`else
   assign hit_match = 1'b0;
`endif

   // row 0 is composed from the values being loaded this cycle so that
   // row_valid can rise one cycle after frame_req
   assign comp_snap = load_row ? slots_nxt  : snap;
   assign comp_off  = load_row ? offset_nxt : offset;
   assign comp_row  = load_row ? 3'd0       : row_idx + 3'd1;

   note_row_compose #(.SLOTS(SLOTS), .COLS(COLS)) u_compose (
      .snap     (comp_snap),
      .offset   (comp_off),
      .row      (comp_row),
      .row_data (comp_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         slots          <= '0;
         snap           <= '0;
         offset         <= 3'd0;
         pend_full      <= 1'b0;
         pend_kind      <= 2'd0;
         tick_pend      <= 1'b0;
         scroll_overrun <= 1'b0;
         exit_valid     <= 1'b0;
         exit_kind      <= 2'd0;
         frame_done     <= 1'b0;
         row_valid      <= 1'b0;
         row_idx        <= 3'd0;
         row_data       <= '0;
      end else begin
         offset <= offset_nxt;
         slots  <= slots_nxt;
         // a matched note on a shift is the one leaving, so only the exit is suppressed
         if (hit_match && !wrap) slots[0] <= KIND_EMPTY;
         // snap takes the pre-hit lane: hits never alter a frame in flight
         if (load_row) snap <= slots_nxt;

         exit_valid <= wrap && (slots[0] != KIND_EMPTY) && !hit_match;
         exit_kind  <= slots[0];

         // a push coinciding with a shift stays pending
         if (push)      begin pend_full <= 1'b1; pend_kind <= note_kind; end
         else if (wrap) pend_full <= 1'b0;

         if (tick_step) tick_pend <= scroll_tick;
         else           tick_pend <= tick_pend || scroll_tick;
         scroll_overrun <= scroll_tick && tick_pend && !tick_step;

         frame_done <= last_row;
         if (load_row || row_step) begin
            row_valid <= 1'b1;
            row_idx   <= comp_row;
            row_data  <= comp_data;
         end else if (last_row) begin
            row_valid <= 1'b0;
            row_idx   <= 3'd0;
            row_data  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_note_lane_renderer.sv
// tb_note_lane_renderer: directed + randomized bench against a pixel-level lane model.
module tb_note_lane_renderer;

   localparam int SLOTS = 10;
   localparam int COLS  = 64;
   localparam int ROW_W = COLS * 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             note_valid = 1'b0;
   logic [1:0]       note_kind = 2'd0;
   logic             note_ready;
   logic             scroll_tick = 1'b0;
   logic             scroll_overrun;
   logic             frame_req = 1'b0;
   logic             row_valid;
   logic             row_ready = 1'b0;
   logic [2:0]       row_idx;
   logic [ROW_W-1:0] row_data;
   logic             frame_done;
   logic             exit_valid;
   logic [1:0]       exit_kind;
`ifdef NOTE_HIT_EN
   logic             hit = 1'b0;
   logic [1:0]       hit_kind = 2'd0;
   logic             hit_ok;
   logic             hit_bad;
   bit               e_hok, e_hbad;
`endif

   note_lane_renderer #(.SLOTS(SLOTS), .COLS(COLS)) dut (
      .clk            (clk),
      .rst            (rst),
      .note_valid     (note_valid),
      .note_kind      (note_kind),
      .note_ready     (note_ready),
      .scroll_tick    (scroll_tick),
      .scroll_overrun (scroll_overrun),
      .frame_req      (frame_req),
      .row_valid      (row_valid),
      .row_ready      (row_ready),
      .row_idx        (row_idx),
      .row_data       (row_data),
      .frame_done     (frame_done),
      .exit_valid     (exit_valid),
      .exit_kind      (exit_kind)
`ifdef NOTE_HIT_EN
      ,
      .hit            (hit),
      .hit_kind       (hit_kind),
      .hit_ok         (hit_ok),
      .hit_bad        (hit_bad)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model: lane contents as plain ints, outputs as expected values
   int m_slots [SLOTS];
   int m_snap  [SLOTS];
   int m_off, m_pk;
   bit m_pf, m_tick;
   bit e_rv, e_done, e_exit, e_ovr;
   int e_ri, e_ek;

   task automatic chk(input string tag, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, act, want);
      end
   endtask

   // ring glyph: border pixels in the edge colour, interior in the fill colour
   function automatic logic [2:0] gpix(input int kind, input int r, input int x);
      bit edge_px;
      edge_px = (r == 0) || (r == 6) || (x == 0) || (x == 6);
      case (kind)
         1:       return edge_px ? 3'b100 : 3'b000;
         2:       return edge_px ? 3'b111 : 3'b011;
         3:       return edge_px ? 3'b110 : 3'b000;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [ROW_W-1:0] exp_row(input int r);
      logic [ROW_W-1:0] v;
      int p;
      v = '0;
      for (int c = 0; c < COLS; c++) begin
         p = c + m_off;
         if (p / 7 < SLOTS) v[c*3 +: 3] = gpix(m_snap[p / 7], r, p % 7);
      end
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < SLOTS; i++) begin m_slots[i] = 0; m_snap[i] = 0; end
      m_off = 0; m_pk = 0; m_pf = 0; m_tick = 0;
      e_rv = 0; e_done = 0; e_exit = 0; e_ovr = 0; e_ri = 0; e_ek = 0;
`ifdef NOTE_HIT_EN
      e_hok = 0; e_hbad = 0;
`endif
   endtask

   task automatic step(input bit nv, input bit [1:0] nk, input bit st, input bit fr, input bit rr);
      bit push, start, hs, used, wrap, hm;
      int old0;
      note_valid = nv; note_kind = nk; scroll_tick = st; frame_req = fr; row_ready = rr;
      push  = nv && !m_pf;
      start = !e_rv && fr;
      hs    = e_rv && rr;
      used  = start && m_tick;
      old0  = m_slots[0];
      hm    = 0;
`ifdef NOTE_HIT_EN
      hm     = hit && old0 != 0 && int'(hit_kind) == old0;
      e_hok  = hm;
      e_hbad = hit && !hm;
`endif
      e_exit = 0; e_done = 0; e_ovr = 0; wrap = 0;
      if (start) begin
         if (used) begin
            m_off = (m_off + 1) % 7;
            wrap  = (m_off == 0);
         end
         if (wrap) begin
            e_exit = (old0 != 0) && !hm;
            e_ek   = old0;
            for (int i = 0; i < SLOTS-1; i++) m_slots[i] = m_slots[i+1];
            m_slots[SLOTS-1] = m_pf ? m_pk : 0;
            m_pf = 0;
         end
         m_snap = m_slots;
         e_rv = 1; e_ri = 0;
      end else if (hs) begin
         if (e_ri == 6) begin e_rv = 0; e_done = 1; end
         else e_ri++;
      end
      if (hm && !wrap) m_slots[0] = 0;
      if (used) m_tick = st;
      else begin
         e_ovr  = st && m_tick;
         m_tick = m_tick || st;
      end
      if (push) begin m_pf = 1; m_pk = int'(nk); end

      @(posedge clk); #1;
      chk("note_ready", note_ready, !m_pf);
      chk("row_valid", row_valid, e_rv);
      if (e_rv) begin
         chk("row_idx", row_idx, e_ri);
         chk("row_data", row_data, exp_row(e_ri));
      end
      chk("frame_done", frame_done, e_done);
      chk("exit_valid", exit_valid, e_exit);
      if (e_exit) chk("exit_kind", exit_kind, e_ek);
      chk("scroll_overrun", scroll_overrun, e_ovr);
`ifdef NOTE_HIT_EN
      chk("hit_ok", hit_ok, e_hok);
      chk("hit_bad", hit_bad, e_hbad);
`endif
   endtask

   task automatic check_reset_outputs();
      chk("rst_row_valid", row_valid, 1'b0);
      chk("rst_row_idx", row_idx, 3'd0);
      chk("rst_row_data", row_data, '0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_exit_valid", exit_valid, 1'b0);
      chk("rst_overrun", scroll_overrun, 1'b0);
      chk("rst_note_ready", note_ready, 1'b0);
   endtask

   initial begin
      logic [20:0] blue_row3;
      blue_row3 = 21'b111011011011011011111;

      // reset, with a frame request held to show it has no effect
      rst = 1'b1; frame_req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      frame_req = 1'b0;
      rst = 1'b0;
      model_reset();

      // push blue and scroll it all the way through the lane and out
      step(1, 2'd2, 0, 0, 1);
      for (int f = 0; f < 77; f++) begin
         step(0, 2'd0, 1, 0, 1);
         step(0, 2'd0, 0, 1, 1);
         for (int j = 0; j < 7; j++) begin
            if (f == 69 && row_idx == 3'd3) chk("blue_row3", row_data[20:0], blue_row3);
            step(0, 2'd0, 0, 0, 1);
         end
      end

      // stall on row 2 with frame_req held, then finish the frame
      step(1, 2'd1, 0, 0, 1);
      step(0, 2'd0, 0, 1, 1);
      step(0, 2'd0, 0, 0, 1);
      step(0, 2'd0, 0, 0, 1);
      repeat (5) step(0, 2'd0, 0, 1, 0);
      repeat (6) step(0, 2'd0, 0, 0, 1);

      // double tick: second one overruns, next frame moves by one
      step(0, 2'd0, 1, 0, 1);
      step(0, 2'd0, 1, 0, 1);
      step(0, 2'd0, 0, 1, 1);
      repeat (8) step(0, 2'd0, 0, 0, 1);

      // tick and frame in the same cycle: tick held for the following frame
      step(0, 2'd0, 1, 1, 1);
      repeat (8) step(0, 2'd0, 0, 0, 1);

      // reset mid-frame aborts without frame_done
      step(0, 2'd0, 0, 1, 1);
      step(0, 2'd0, 0, 0, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_row_valid", row_valid, 1'b0);
      chk("abort_frame_done", frame_done, 1'b0);
      rst = 1'b0;
      model_reset();

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
`ifdef NOTE_HIT_EN
         hit      = ($urandom % 6) == 0;
         hit_kind = 2'($urandom % 4);
`endif
         step(($urandom % 3) == 0, 2'($urandom % 4), ($urandom % 3) == 0,
              ($urandom % 3) == 0, ($urandom % 4) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
